// File: rtl/core_pkg.sv
// Shared core definitions: sequencer states, RV32 opcode constants and
// branch/jump immediate extraction used by both the sequencer and decoder.
package core_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } seq_state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   function automatic logic [31:0] imm_b(input logic [31:0] ins);
      return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] ins);
      return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/pc_next_gen.sv
// Combinational next-PC selection and JAL link address; all arithmetic
// wraps modulo 2^PC_W.
module pc_next_gen
   import core_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic [PC_W-1:0] pc,
   input  logic [31:0]     instr,
   input  logic            jump,
   input  logic            take_branch,
   output logic [PC_W-1:0] next_pc,
   output logic [PC_W-1:0] link_addr
);

   logic [PC_W-1:0] off_b;
   logic [PC_W-1:0] off_j;

   // signed cast sign-extends when PC_W exceeds 32, truncates otherwise
   assign off_b     = PC_W'($signed(imm_b(instr)));
   assign off_j     = PC_W'($signed(imm_j(instr)));
   assign link_addr = pc + PC_W'(4);

   always_comb begin
      next_pc = link_addr;
      if (jump) begin
         next_pc = pc + off_j;
      end else if (take_branch) begin
         next_pc = pc + off_b;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32 instruction sequencer: owns PC and instruction register
// and issues Moore phase strobes for fetch, ALU, data memory and writeback.
//
// state     | meaning
// ST_FETCH  | imem_req high, waiting for imem_ready
// ST_DECODE | decoder flags settle from instr; unknown opcode retires as NOP
// ST_EXEC   | alu_en pulse; branches retire here
// ST_MEM    | dmem_req held until dmem_ready; stores retire here
// ST_WB     | reg_we pulse, then retire
// ST_HALT   | parked until halt_req drops
module instr_sequencer
   import core_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   input  logic            alu_op_on,
   input  logic            load_on,
   input  logic            store_on,
   input  logic            jump,
   input  logic            branch,
   input  logic            branch_taken,
   output logic            alu_en,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ready,
   output logic            reg_we,
   output logic [PC_W-1:0] link_addr,
   output logic [PC_W-1:0] pc,
   input  logic            halt_req,
   output logic            halted,
   output logic [31:0]     retired
);

   seq_state_t      state;
   seq_state_t      state_nxt;
   logic            run;
   logic            retire;
   logic            take_branch;
   logic            any_class;
   logic [PC_W-1:0] next_pc;

   assign any_class   = alu_op_on | load_on | store_on | jump | branch;
   assign take_branch = (state == ST_EXEC) & branch & branch_taken;

   pc_next_gen #(.PC_W(PC_W)) u_pc_next_gen (
      .pc          (pc),
      .instr       (instr),
      .jump        (jump),
      .take_branch (take_branch),
      .next_pc     (next_pc),
      .link_addr   (link_addr)
   );

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         ST_FETCH: begin
            if (run && imem_ready) state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            if (any_class) state_nxt = ST_EXEC;
            else           retire    = 1'b1;
         end
         ST_EXEC: begin
            // jump outranks load_on so a JAL never touches data memory
            if (jump || alu_op_on)         state_nxt = ST_WB;
            else if (load_on || store_on)  state_nxt = ST_MEM;
            else                           retire    = 1'b1;
         end
         ST_MEM: begin
            if (dmem_ready) begin
               if (store_on) retire    = 1'b1;
               else          state_nxt = ST_WB;
            end
         end
         ST_WB: begin
            retire = 1'b1;
         end
         ST_HALT: begin
            if (!halt_req) state_nxt = ST_FETCH;
         end
         default: begin
            state_nxt = ST_FETCH;
         end
      endcase
      if (retire) state_nxt = halt_req ? ST_HALT : ST_FETCH;
   end

   // run keeps the fetch request low for the cycle after reset is sampled
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_FETCH;
         run     <= 1'b0;
         pc      <= RESET_PC;
         instr   <= '0;
         retired <= '0;
      end else begin
         run   <= 1'b1;
         state <= state_nxt;
         if (state == ST_FETCH && run && imem_ready) instr <= imem_rdata;
         if (retire) begin
            pc      <= next_pc;
            retired <= retired + 32'd1;
         end
      end
   end

   assign imem_req  = run && (state == ST_FETCH);
   assign imem_addr = pc;
   assign alu_en    = (state == ST_EXEC);
   assign dmem_req  = (state == ST_MEM);
   assign dmem_we   = (state == ST_MEM) && store_on;
   assign reg_we    = (state == ST_WB);
   assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: each instruction pushes its expected retire
// record into a scoreboard that is popped when the DUT retires it.
module tb_instr_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic        alu_op_on, load_on, store_on, jump, branch;
   logic        branch_taken = 1'b0;
   logic        alu_en, dmem_req, dmem_we, reg_we, halted;
   logic        dmem_ready = 1'b0;
   logic        halt_req = 1'b0;
   logic [31:0] link_addr, pc, retired;

   instr_sequencer #(.PC_W(32), .RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .instr        (instr),
      .alu_op_on    (alu_op_on),
      .load_on      (load_on),
      .store_on     (store_on),
      .jump         (jump),
      .branch       (branch),
      .branch_taken (branch_taken),
      .alu_en       (alu_en),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ready   (dmem_ready),
      .reg_we       (reg_we),
      .link_addr    (link_addr),
      .pc           (pc),
      .halt_req     (halt_req),
      .halted       (halted),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   // decoder stand-in; JAL also raises load_on to exercise jump priority
   always_comb begin
      alu_op_on = (instr[6:0] == 7'h33) || (instr[6:0] == 7'h13);
      load_on   = (instr[6:0] == 7'h03) || (instr[6:0] == 7'h6F);
      store_on  = (instr[6:0] == 7'h23);
      jump      = (instr[6:0] == 7'h6F);
      branch    = (instr[6:0] == 7'h63);
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] cyc;
      logic [31:0] we;
      logic [31:0] dmem;
      logic [31:0] alu;
      logic [31:0] link;
      logic [31:0] ret;
      logic        dwe;
   } exp_t;

   exp_t        sb[$];
   int          n_err = 0;
   int          n_chk = 0;
   logic [31:0] model_pc;
   logic [31:0] model_ret;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_b(input int imm);
      logic [12:0] v;
      v = 13'(imm);
      return {v[12], v[10:5], 5'd0, 5'd0, 3'b000, v[4:1], v[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input int imm);
      logic [20:0] v;
      v = 21'(imm);
      return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'h6F};
   endfunction

   task automatic run_instr(input logic [31:0] ins, input int off, input int iw,
                            input int dw, input bit taken, input bit hreq);
      exp_t        e;
      exp_t        got;
      logic [6:0]  op;
      int          cyc, fcnt, dcnt, we_n, dm_n, alu_n, we_pos;
      logic        dwe_obs;
      logic [31:0] link_obs, ret0;
      bit          is_j, is_b, is_ld, is_st, is_alu;
      op = ins[6:0];
      cyc = 0; fcnt = 0; dcnt = 0; we_n = 0; dm_n = 0; alu_n = 0; we_pos = 0;
      dwe_obs = 1'b0; link_obs = '0;
      is_j   = (op == 7'h6F);
      is_b   = (op == 7'h63);
      is_ld  = (op == 7'h03);
      is_st  = (op == 7'h23);
      is_alu = (op == 7'h33) || (op == 7'h13);
      e.link = model_pc + 32'd4;
      e.pc   = (is_j || (is_b && taken)) ? model_pc + 32'(off) : model_pc + 32'd4;
      e.cyc  = 32'(iw + ((is_j || is_alu) ? 4 : is_ld ? 5 + dw : is_st ? 4 + dw : is_b ? 3 : 2));
      e.we   = (is_j || is_alu || is_ld) ? 32'd1 : 32'd0;
      e.dmem = (is_ld || is_st) ? 32'(1 + dw) : 32'd0;
      e.alu  = (is_j || is_alu || is_ld || is_st || is_b) ? 32'd1 : 32'd0;
      e.dwe  = is_st;
      e.ret  = model_ret + 32'd1;
      sb.push_back(e);

      imem_rdata   = ins;
      branch_taken = taken;
      for (int i = 0; i < 50 && !imem_req; i++) @(negedge clk);
      ret0 = retired;
      while (cyc < 100) begin
         if (reg_we) begin
            we_n++;
            we_pos = cyc + 1;
         end
         if (dmem_req) begin
            if (dm_n == 0) dwe_obs = dmem_we;
            dm_n++;
            if (hreq) halt_req = 1'b1;
         end
         if (alu_en) alu_n++;
         if (cyc == 0) link_obs = link_addr;
         imem_ready = imem_req && (fcnt >= iw);
         if (imem_req) fcnt++;
         dmem_ready = dmem_req && (dcnt >= dw);
         if (dmem_req) dcnt++;
         @(negedge clk);
         cyc++;
         if (retired != ret0) break;
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;

      got = sb.pop_front();
      check_val("retired", retired, got.ret);
      check_val("pc", pc, got.pc);
      check_val("cycles", 32'(cyc), got.cyc);
      check_val("reg_we_count", 32'(we_n), got.we);
      check_val("dmem_req_cycles", 32'(dm_n), got.dmem);
      check_val("alu_en_count", 32'(alu_n), got.alu);
      check_val("link_addr", link_obs, got.link);
      if (got.we != 0) check_val("reg_we_cycle", 32'(we_pos), got.cyc);
      if (got.dmem != 0) check_val("dmem_we", 32'(dwe_obs), 32'(got.dwe));

      if (hreq) begin
         check_val("halted", 32'(halted), 32'd1);
         check_val("halt_imem_req", 32'(imem_req), 32'd0);
         repeat (3) @(negedge clk);
         check_val("halt_pc_hold", pc, got.pc);
         check_val("halt_hold", 32'(halted), 32'd1);
         halt_req = 1'b0;
         @(negedge clk);
         check_val("resume_req", 32'(imem_req), 32'd1);
         check_val("resume_addr", imem_addr, got.pc);
      end
      model_pc  = got.pc;
      model_ret = got.ret;
   endtask

   initial begin
      model_pc  = RST_PC;
      model_ret = '0;
      repeat (3) @(negedge clk);
      check_val("rst_pc", pc, RST_PC);
      check_val("rst_instr", instr, 32'd0);
      check_val("rst_retired", retired, 32'd0);
      check_val("rst_halted", 32'(halted), 32'd0);
      check_val("rst_imem_req", 32'(imem_req), 32'd0);
      check_val("rst_strobes", 32'({alu_en, dmem_req, reg_we}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("boot_imem_req", 32'(imem_req), 32'd1);
      check_val("boot_imem_addr", imem_addr, RST_PC);

      run_instr(32'h002081B3, 0, 0, 0, 1'b0, 1'b0);     // ADD
      run_instr(32'h00108093, 0, 0, 0, 1'b0, 1'b0);     // ADDI
      run_instr(32'h0000A103, 0, 0, 3, 1'b0, 1'b0);     // LW, slow dmem
      run_instr(enc_j(-236), -236, 0, 0, 1'b0, 1'b0);   // JAL 0x10C -> 0x20
      run_instr(enc_b(-8), -8, 0, 0, 1'b0, 1'b0);       // BEQ not taken
      run_instr(enc_j(-4), -4, 0, 0, 1'b0, 1'b0);       // JAL 0x24 -> 0x20
      run_instr(enc_b(-8), -8, 0, 0, 1'b1, 1'b0);       // BEQ taken -> 0x18
      run_instr(enc_j(-28), -28, 0, 0, 1'b0, 1'b0);     // JAL -> 0xFFFFFFFC
      run_instr(enc_j(32'h7FE), 32'h7FE, 0, 0, 1'b0, 1'b0); // wraps to 0x7FA
      run_instr(32'h0020A023, 0, 0, 1, 1'b0, 1'b1);     // SW with halt in MEM
      run_instr(32'h00000000, 0, 2, 0, 1'b0, 1'b0);     // unknown opcode
      run_instr(32'h00108093, 0, 1, 0, 1'b0, 1'b0);     // ADDI, slow imem

      // reset while a fetch is stalled
      imem_ready = 1'b0;
      for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_val("stall_req", 32'(imem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("mid_rst_req", 32'(imem_req), 32'd0);
      check_val("mid_rst_pc", pc, RST_PC);
      check_val("mid_rst_retired", retired, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_req", 32'(imem_req), 32'd1);
      check_val("post_rst_addr", imem_addr, RST_PC);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle sequencer for the RV32 core: owns the program counter and the instruction register, and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It sits between the instruction/data memories and the combinational decoder. It feeds the decoder the latched instruction, consumes the decoded class flags, and emits the one-cycle phase enables that gate the ALU, data memory and register file. It also handles PC redirection for branches and JAL, plus a halt request.

## Interface
Parameters:
- `PC_W`, default 32: program counter width.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out PC_W: fetch address, equal to `pc`.
- `imem_ready` in 1: fetch data valid this cycle.
- `imem_rdata` in 32: fetched instruction.
- `instr` out 32: latched instruction register, drives the decoder.
- `alu_op_on`, `load_on`, `store_on`, `jump`, `branch` in 1 each: decoded class flags, taken from `instr`.
- `branch_taken` in 1: ALU compare result, valid in EXEC.
- `alu_en` out 1: ALU operand/result capture enable.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: store when high, load when low.
- `dmem_ready` in 1: data access complete.
- `reg_we` out 1: register-file write strobe.
- `link_addr` out PC_W: `pc + 4`, the JAL writeback value.
- `pc` out PC_W: current PC.
- `halt_req` in 1: stop at the next instruction boundary.
- `halted` out 1: the sequencer is parked.
- `retired` out 32: count of retired instructions, wraps.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters FETCH.
- FETCH:
  - `imem_req=1`.
  - On `imem_ready`: `instr<=imem_rdata`, go to DECODE.
  - Otherwise hold, with no timeout.
- DECODE: one cycle; the flags settle from `instr`.
  - No flag set (unknown opcode): treat as a NOP and retire (PC+4).
  - Otherwise go to EXEC.
- EXEC: `alu_en=1` for one cycle. Next step by class:
  - load/store: go to MEM.
  - alu_op_on or jump: go to WB.
  - branch: retire here.
- MEM:
  - `dmem_req=1`, `dmem_we=store_on`, held until `dmem_ready`.
  - Then load goes to WB; store retires.
- WB: `reg_we=1` for exactly one cycle, then retire.
- Retire, on the last cycle of the instruction:
  - `retired<=retired+1`.
  - PC update:
    - jump: `pc<=pc+imm_j`.
    - branch with `branch_taken`: `pc<=pc+imm_b`.
    - otherwise: `pc<=pc+4`.
  - Then go to FETCH, or to HALT if `halt_req` is sampled high on that cycle.
- Immediates, sign-extended to PC_W; all PC arithmetic is modulo 2^PC_W:
  - `imm_b={instr[31],instr[7],instr[30:25],instr[11:8],1'b0}`.
  - `imm_j={instr[31],instr[19:12],instr[20],instr[30:21],1'b0}`.
- If both load_on and jump are set (JAL encoding), jump takes priority and there is no MEM access.
- HALT:
  - `halted=1`; all strobes are low.
  - When `halt_req` deasserts, go to FETCH with the PC unchanged.
  - A `halt_req` mid-instruction has no effect until retire.

## Timing
- Reset values: `pc=RESET_PC`, `instr=0`, `retired=0`, `halted=0`, and all strobes 0.
- `rst` overrides everything, including an outstanding imem/dmem handshake. The request drops the cycle after `rst` is sampled.
- All strobes are registered-state decodes (Moore outputs), with no combinational path from `*_ready` to `*_req`.
- Minimum cycles with zero-wait memories:
  - ALU/JAL: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - NOP: 2.
- Each extra wait cycle on `imem_ready` or `dmem_ready` adds exactly one cycle.
- `pc` changes only on the retire edge. `imem_addr` is stable throughout a FETCH.
- `retired` wraps from 0xFFFFFFFF to 0.

## Structure
- Shared package `core_pkg`:
  - State enum.
  - Opcode constants (R, I, LOAD, STORE, BRANCH, JAL), also used by the decoder.
  - `imm_b`/`imm_j` extract functions.
- Sub-module `pc_next_gen`: combinational next-PC and `link_addr` computation. The FSM and registers stay in the top module.

## Test plan
- Reset: `RESET_PC=0x100`, release `rst` -> `imem_addr=0x100`, `imem_req=1`, `retired=0`, `halted=0`.
- ADD followed by ADDI, zero-wait memories -> `reg_we` pulses at cycles 4 and 8, PC reads 0x104 then 0x108, `retired=2`.
- Load with `dmem_ready` delayed 3 cycles -> `dmem_req` high for 4 cycles with `dmem_we=0`, `reg_we` one cycle later, 8 cycles total.
- BEQ with imm_b=-8 at pc=0x20:
  - taken -> pc=0x18.
  - not taken -> pc=0x24.
  - `reg_we` never asserts.
- JAL with imm_j=0x7FE at pc=0xFFFFFFFC -> `link_addr=0x0` (wrap), pc=0x7FA, one `reg_we`, no `dmem_req`.
- Mid-operation events:
  - `halt_req` asserted during MEM -> the store completes, `retired` increments, state becomes HALT with `halted=1`; releasing `halt_req` resumes fetch at the next PC.
  - `rst` during a FETCH wait -> `imem_req` drops and PC returns to RESET_PC.
